// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: program-memory req/ack channel, decode valid/ready channel and redirect/halt.
// master = fetch stage; slave = program memory plus decode side.
interface instr_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic              ir_valid;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;

  modport master (
    output mem_req, mem_addr, ir_valid, ir, ir_pc, halted,
    input  mem_ack, mem_rdata, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, ir_valid, ir, ir_pc, halted,
    output mem_ack, mem_rdata, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding program-memory fetch, instruction queue to decode.
// Optional macro IFETCH_BYPASS_EN forwards an acked word straight to decode when the queue is empty.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);
  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [3:0]       HALT_OP = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              halted_q, halted_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       word_q [DEPTH];
  logic [ADDR_W-1:0] wpc_q  [DEPTH];

  logic ack_s;
  logic fetch_ack_s;
  logic halt_word_s;
  logic q_valid_s;
  logic push_s;
  logic pop_s;

  assign ack_s       = req_q & bus.mem_ack;
  assign fetch_ack_s = ack_s & (state_q == ST_FETCH);
  assign halt_word_s = (bus.mem_rdata[15:12] == HALT_OP);
  assign q_valid_s   = (count_q != {CNT_W{1'b0}});
  assign pop_s       = q_valid_s & bus.ir_ready & ~bus.redirect;

`ifdef IFETCH_BYPASS_EN
  logic bypass_s;
  assign bypass_s = fetch_ack_s & ~q_valid_s & ~bus.redirect;
  // A bypassed word taken by decode in the same cycle never enters the queue
  assign push_s   = fetch_ack_s & ~bus.redirect & ~(bypass_s & bus.ir_ready);

  // Decode view: live memory word when bypassing, queue head otherwise
  always_comb begin
    if (bypass_s) begin
      bus.ir_valid = 1'b1;
      bus.ir       = bus.mem_rdata;
      bus.ir_pc    = addr_q;
    end else begin
      bus.ir_valid = q_valid_s;
      bus.ir       = word_q[rd_ptr_q];
      bus.ir_pc    = wpc_q[rd_ptr_q];
    end
  end
`else
  assign push_s       = fetch_ack_s & ~bus.redirect;
  assign bus.ir_valid = q_valid_s;
  assign bus.ir       = word_q[rd_ptr_q];
  assign bus.ir_pc    = wpc_q[rd_ptr_q];
`endif

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;
  assign bus.halted   = halted_q;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; redirect overrides, and only an unanswered request forces DISCARD
  always_comb begin
    state_d = state_q;
    if (bus.redirect) begin
      if (req_q && !bus.mem_ack) begin
        state_d = ST_DISCARD;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (fetch_ack_s && halt_word_s) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (ack_s) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // FSM outputs: PC, queue bookkeeping, next request and halted flag
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    req_d    = req_q;
    addr_d   = addr_q;
    halted_d = 1'b0;

    if (bus.redirect) begin
      pc_d     = bus.redirect_pc;
      count_d  = {CNT_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
    end else begin
      if (fetch_ack_s) begin
        pc_d = pc_q + ADDR_W'(1);
      end else begin
        pc_d = pc_q;
      end
      count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
    end

    // Requests are never withdrawn; a new one needs a slot free after this cycle's push/pop
    if (req_q && !bus.mem_ack) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = (state_d == ST_FETCH) && (count_d < FULL_C);
      addr_d = pc_d;
    end

    if ((state_d == ST_HALT) && (count_d == {CNT_W{1'b0}})) begin
      halted_d = 1'b1;
    end else begin
      halted_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= {ADDR_W{1'b0}};
      req_q    <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      halted_q <= 1'b0;
      count_q  <= {CNT_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
    end else begin
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      halted_q <= halted_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Queue storage; cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= 16'h0000;
        wpc_q[i]  <= {ADDR_W{1'b0}};
      end
    end else if (push_s) begin
      word_q[wr_ptr_q] <= bus.mem_rdata;
      wpc_q[wr_ptr_q]  <= addr_q;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a queue-based model of the fetch stream predicts every output.
module tb_instr_fetch;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [15:0] word;
    logic [7:0]  pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset;

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();
  instr_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] prog [256];
  ent_t        exp_q [$];
  logic [7:0]  exp_pc;
  logic [7:0]  held_addr;
  bit          held;
  bit          stale;
  bit          halt_mode;
  int          wait_left;
  int          wait_min;
  int          wait_max;
  int          ready_pct;
  int          ack_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pc    = 8'h00;
    held_addr = 8'h00;
    held      = 1'b0;
    stale     = 1'b0;
    halt_mode = 1'b0;
    wait_left = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".mem_req"},  32'(bus.mem_req),  32'd0);
    check_eq({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check_eq({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'd0);
    check_eq({tag, ".ir"},       32'(bus.ir),       32'd0);
    check_eq({tag, ".ir_pc"},    32'(bus.ir_pc),    32'd0);
    check_eq({tag, ".halted"},   32'(bus.halted),   32'd0);
  endtask

  task automatic check_outputs();
    bit exp_req;
    exp_req = held || (!halt_mode && (exp_q.size() < DEPTH));
    check_eq("mem_req", 32'(bus.mem_req), 32'(exp_req));
    if (exp_req) begin
      check_eq("mem_addr", 32'(bus.mem_addr), 32'(held ? held_addr : exp_pc));
    end
    check_eq("ir_valid", 32'(bus.ir_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("ir",    32'(bus.ir),    32'(exp_q[0].word));
      check_eq("ir_pc", 32'(bus.ir_pc), 32'(exp_q[0].pc));
    end
    check_eq("halted", 32'(bus.halted), 32'(halt_mode && (exp_q.size() == 0)));
  endtask

  // One cycle: check outputs, then act as memory/decode and advance the model
  task automatic step(input bit redir, input logic [7:0] rpc);
    bit exp_req;
    bit ack;
    bit ready;
    bit pop;
    @(negedge clk);
    check_outputs();
    exp_req = held || (!halt_mode && (exp_q.size() < DEPTH));
    if (exp_req && !held) begin
      held_addr = exp_pc;
      wait_left = int'($urandom_range(wait_max, wait_min));
    end
    ack = exp_req && (wait_left == 0);
    if (exp_req && !ack) wait_left--;
    ready = ($urandom_range(99, 0) < ready_pct);

    bus.mem_ack     = ack;
    bus.mem_rdata   = ack ? prog[held_addr] : 16'($urandom);
    bus.ir_ready    = ready;
    bus.redirect    = redir;
    bus.redirect_pc = redir ? rpc : 8'($urandom);
    if (ack) ack_count++;

    pop = (exp_q.size() != 0) && ready && !redir;
    if (redir) begin
      exp_q.delete();
      exp_pc    = rpc;
      halt_mode = 1'b0;
      stale     = exp_req && !ack;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (ack && stale) begin
        stale = 1'b0;
      end else if (ack) begin
        exp_q.push_back({prog[held_addr], held_addr});
        exp_pc = exp_pc + 8'd1;
        if (prog[held_addr][15:12] == 4'hF) halt_mode = 1'b1;
      end
    end
    held = exp_req && !ack;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 16'h0000;
    bus.ir_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    reset           = 1'b0;
    model_reset();
    wait_min  = 0;
    wait_max  = 0;
    ready_pct = 100;
    ack_count = 0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;

    // Straight-line fetch up to a halt word
    prog[0] = 16'h0123;
    prog[1] = 16'h1456;
    prog[2] = 16'hF000;
    prog[3] = 16'h2333;
    repeat (10) step(1'b0, 8'h00);
    check_eq("straight.halted", 32'(bus.halted), 32'd1);

    // Backpressure: four acks fill the queue, then the request drops
    for (int i = 0; i < 8; i++) prog[i] = 16'h5000 | 16'(i);
    ready_pct = 0;
    step(1'b1, 8'h00);
    ack_count = 0;
    repeat (10) step(1'b0, 8'h00);
    check_eq("backpressure.acks", 32'(ack_count), 32'd4);
    ready_pct = 100;
    repeat (8) step(1'b0, 8'h00);

    // Wait states of three cycles
    wait_min = 3;
    wait_max = 3;
    step(1'b1, 8'h20);
    repeat (12) step(1'b0, 8'h00);

    // Redirect while a request to 5 is outstanding
    prog[5] = 16'hDEAD;
    step(1'b1, 8'h05);
    repeat (5) step(1'b0, 8'h00);
    step(1'b1, 8'h05);
    step(1'b0, 8'h00);
    step(1'b1, 8'h40);
    repeat (10) step(1'b0, 8'h00);

    // Wrap from FF to 00, halt, then restart at 10
    wait_min = 0;
    wait_max = 0;
    prog[8'hFF] = 16'h3FFF;
    prog[8'h00] = 16'h4000;
    prog[8'h01] = 16'hF001;
    for (int i = 16; i < 24; i++) prog[i] = 16'h6000 | 16'(i);
    step(1'b1, 8'hFF);
    repeat (8) step(1'b0, 8'h00);
    check_eq("wrap.halted", 32'(bus.halted), 32'd1);
    step(1'b1, 8'h10);
    repeat (6) step(1'b0, 8'h00);

    // Random traffic with wait states, backpressure and redirects
    wait_min  = 0;
    wait_max  = 3;
    ready_pct = 70;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(15, 0) == 0) begin
        step(1'b1, ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom));
      end else begin
        step(1'b0, 8'h00);
      end
    end

    // Asynchronous reset with three words queued
    for (int i = 0; i < 8; i++) prog[8'h30 + i] = 16'h7000 | 16'(i);
    wait_min  = 0;
    wait_max  = 0;
    ready_pct = 0;
    step(1'b1, 8'h30);
    repeat (3) step(1'b0, 8'h00);
    @(negedge clk);
    check_outputs();
    check_eq("prereset.depth", 32'(exp_q.size()), 32'd3);
    #2;
    reset        = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.redirect = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    reset     = 1'b1;
    ready_pct = 100;
    repeat (8) step(1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the CPU decode/execute stage. Owns the program counter, fetches 16-bit instruction words from program memory over a req/ack handshake, buffers them in a small queue, and presents them to decode with valid/ready. Stops fetching after a halt opcode (`4'b1111`) and restarts on a redirect.

## Interface

Parameters:
- `ADDR_W`, default 8: program-memory word-address width.
- `DEPTH`, default 4: instruction queue entries; must be a power of two and at least 2.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `mem_req`, out, 1: fetch request to program memory.
- `mem_addr`, out, `ADDR_W`: word address of the request.
- `mem_ack`, in, 1: memory returns `mem_rdata` in this cycle.
- `mem_rdata`, in, 16: instruction word.
- `ir_valid`, out, 1: `ir`/`ir_pc` hold a valid instruction.
- `ir`, out, 16: instruction word at the queue head.
- `ir_pc`, out, `ADDR_W`: address of `ir`.
- `ir_ready`, in, 1: decode consumes the head this cycle if `ir_valid`.
- `redirect`, in, 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc`, in, `ADDR_W`: new fetch address.
- `halted`, out, 1: halt word consumed and queue empty; fetch stopped.

## Operation

- PC counts words. It increments by 1 per accepted fetch and wraps from `2^ADDR_W-1` to 0.
- FSM states:
  - FETCH: a request is outstanding or may be issued.
  - DISCARD: waiting for the ack of a request that was cancelled by a redirect.
  - HALT: fetch stopped.
- At most one request is outstanding at a time. A request is issued only when the queue has a free slot.
- `mem_req` and `mem_addr` are held stable from assertion until the cycle of `mem_ack`, inclusive. A request is never withdrawn, including across a redirect.
- On `mem_ack` in FETCH:
  - Push `{mem_rdata, mem_addr}` into the queue; PC = PC+1.
  - If `mem_rdata[15:12]==4'b1111`, go to HALT and issue no further requests.
- HALT: `halted` = 1 once the halt word has been popped and the queue is empty.
- `redirect` (any state):
  - Flush the queue; PC = `redirect_pc`; deassert `halted`.
  - If a request is outstanding and not acked this cycle, go to DISCARD. Otherwise go to FETCH.
- DISCARD: keep `mem_req`/`mem_addr` at the old values. On `mem_ack`, drop the data and go to FETCH.
- Redirect during DISCARD: update PC only; stay in DISCARD.
- Queue: push and pop in the same cycle are legal, including when the queue is full (pop frees the slot used by the push). Occupancy never exceeds `DEPTH`.
- A pop happens when `ir_valid && ir_ready`.

## Timing

- Reset values: `mem_req`=0, `mem_addr`=0, `ir_valid`=0, `ir`=0, `ir_pc`=0, `halted`=0. PC=0, state FETCH, queue empty.
- The first `mem_req` is asserted in the first cycle after `reset` deasserts, with `mem_addr`=0.
- Latency: `mem_ack` at edge N gives `ir_valid`=1 after edge N (registered queue).
- With zero-wait memory (ack in the request cycle) and `ir_ready`=1, throughput is one word per cycle.
- Same cycle `redirect` and `mem_ack`: the ack completes the old request, its data is discarded, and the next request goes to `redirect_pc` the following cycle.
- Same cycle `redirect` and pop: the pop is ignored and the flush wins.
- `ir_valid` is 0 in the cycle after a redirect.
- `reset` asserted mid-request: all state returns to reset values immediately. Memory must tolerate the abandoned request.

## Configuration

- `IFETCH_BYPASS_EN` defined:
  - When the queue is empty and `mem_ack`=1 in FETCH, `ir`/`ir_pc` are driven combinationally from `mem_rdata`/`mem_addr` and `ir_valid`=1 in the same cycle.
  - If `ir_ready`=1 that cycle, the word is not pushed.
- Undefined: no combinational path from memory to decode; 1-cycle minimum latency as above.

## Test plan

- **Reset, straight-line fetch.** Zero-wait memory returns `16'h0123,16'h1456,16'hF000` at addresses 0,1,2; `ir_ready`=1. Expect `ir` sequence `0123`(pc 0), `1456`(pc 1), `F000`(pc 2). No request to address 3. `halted`=1 one cycle after `F000` is popped.
- **Backpressure.** `ir_ready`=0, `DEPTH`=4, zero-wait memory. Expect exactly 4 acks, then `mem_req` low. Raising `ir_ready` drains in order 0..3 and fetching resumes at address 4.
- **Wait states.** Ack delayed 3 cycles. `mem_req`/`mem_addr` stay constant through all 4 cycles. Word appears on `ir` the cycle after the ack.
- **Redirect with request outstanding.** Request to 5 pending; `redirect`=1, `redirect_pc`=8'h40. Queue flushes, `mem_addr` stays 5 until ack, that data never appears on `ir`, and the next request is to `8'h40`.
- **Wrap and halt restart.** PC starts at 8'hFF. Fetch order is FF then 00. After halt, `redirect_pc`=8'h10 clears `halted` and fetching resumes at 8'h10.
- **Async reset mid-stream.** `reset` low with 3 queued words. Outputs are at reset values before the next clock edge. Refetch starts at 0.
